// File: rtl/uart_pkg.sv
// Shared constants and timing helpers for the 64-bit serial link.
// Both ends derive bit and timeout counts from the same functions.
package uart_pkg;

   localparam logic [7:0] HEADER = 8'hA5;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PAYLOAD = 2'd1;
   localparam logic [1:0] ST_CHECK   = 2'd2;

   function automatic int bps_cnt(input int clk_freq, input int bps);
      return clk_freq / bps;
   endfunction

   function automatic int tmo_width(input int bits, input int bcnt);
      return $clog2(bits * bcnt + 1);
   endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: input synchroniser, start-glitch reject,
// mid-bit sampling and stop-bit check.
module uart_byte_rx #(
   parameter int BPS_CNT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rxd,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       stop_err
);

   localparam int CW = $clog2(BPS_CNT);
   localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);
   localparam logic [CW-1:0] MID  = CW'(BPS_CNT / 2);

   logic          s1, s2, s3;
   logic          busy;
   logic [3:0]    bit_idx;
   logic [CW-1:0] cnt;
   logic          fall;

   assign fall = s3 & ~s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1         <= 1'b1;
         s2         <= 1'b1;
         s3         <= 1'b1;
         busy       <= 1'b0;
         bit_idx    <= '0;
         cnt        <= '0;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
      end else begin
         s1         <= uart_rxd;
         s2         <= s1;
         s3         <= s2;
         byte_valid <= 1'b0;
         stop_err   <= 1'b0;
         if (!busy) begin
            if (fall) begin
               busy    <= 1'b1;
               cnt     <= '0;
               bit_idx <= '0;
            end
         end else begin
            if (cnt == LAST) begin
               cnt     <= '0;
               bit_idx <= bit_idx + 4'd1;
            end else begin
               cnt <= cnt + CW'(1);
            end
            // Idle again at mid-stop so a start edge half a bit later is seen
            if (cnt == MID) begin
               unique case (1'b1)
                  bit_idx == 4'd0: begin
                     if (s2) busy <= 1'b0;
                  end
                  bit_idx == 4'd9: begin
                     busy       <= 1'b0;
                     byte_valid <= 1'b1;
                     stop_err   <= ~s2;
                  end
                  default: byte_data <= {s2, byte_data[7:1]};
               endcase
            end
         end
      end
   end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receiver: header hunt, 8-byte payload, XOR checksum and
// inter-byte timeout; data_64 only ever takes a fully checked payload.
module uart_frame_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ     = 50_000_000,
   parameter int UART_BPS     = 115200,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        uart_rxd,
   output logic [63:0] data_64,
   output logic        data_out_done,
   output logic        frame_err
);

   localparam int BPS = bps_cnt(CLK_FREQ, UART_BPS);
   localparam int TMO = TIMEOUT_BITS * BPS;
   localparam int TW  = tmo_width(TIMEOUT_BITS, BPS);

   logic [7:0]    byte_data;
   logic          byte_valid;
   logic          stop_err;
   logic [1:0]    state;
   logic [2:0]    idx;
   logic [63:0]   shadow;
   logic [7:0]    xsum;
   logic [TW-1:0] tmo_cnt;
   logic          in_frame, timeout;
   logic          ev_hdr, ev_abort, ev_data, ev_check;

   uart_byte_rx #(.BPS_CNT(BPS)) u_byte (
      .clk        (clk),
      .rst_n      (rst_n),
      .uart_rxd   (uart_rxd),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .stop_err   (stop_err)
   );

   assign in_frame = (state != ST_IDLE);
   assign timeout  = in_frame && !byte_valid && (tmo_cnt == TW'(TMO - 1));
   assign ev_hdr   = byte_valid && !in_frame;
   assign ev_abort = in_frame && (timeout || (byte_valid && stop_err));
   assign ev_data  = byte_valid && !stop_err && (state == ST_PAYLOAD);
   assign ev_check = byte_valid && !stop_err && (state == ST_CHECK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         idx           <= '0;
         shadow        <= '0;
         xsum          <= '0;
         tmo_cnt       <= '0;
         data_64       <= '0;
         data_out_done <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         data_out_done <= 1'b0;
         frame_err     <= 1'b0;
         // Reload to 1 so the pulse lands TMO clocks after byte_valid
         if (byte_valid) tmo_cnt <= TW'(1);
         else if (in_frame) tmo_cnt <= tmo_cnt + TW'(1);
         unique case (1'b1)
            ev_hdr: begin
               if (!stop_err && byte_data == HEADER) begin
                  state <= ST_PAYLOAD;
                  idx   <= '0;
                  xsum  <= '0;
               end
            end
            ev_abort: begin
               frame_err <= 1'b1;
               state     <= ST_IDLE;
            end
            ev_data: begin
               shadow[{idx, 3'b000} +: 8] <= byte_data;
               xsum <= xsum ^ byte_data;
               idx  <= idx + 3'd1;
               if (idx == 3'd7) state <= ST_CHECK;
            end
            ev_check: begin
               if (byte_data == xsum) begin
                  data_64       <= shadow;
                  data_out_done <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
               state <= ST_IDLE;
            end
            default: ;
         endcase
      end
   end

endmodule
